// File: rtl/vx_commit_arb.sv
// vx_commit_arb: merges NUM_EX execution-unit commit streams into one
// registered commit stream. Round-robin arbitration, packet-atomic for
// multi-packet instructions (sop ... eop), plus a committed-instruction
// counter that feeds the performance monitors.
module vx_commit_arb #(
    parameter int NUM_EX = 4,
    parameter int DATAW  = 64,
    parameter int PERF_W = 44,
    localparam int IDX_W = (NUM_EX > 1) ? $clog2(NUM_EX) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_EX-1:0]       valid_in,
    input  logic [NUM_EX*DATAW-1:0] data_in,
    output logic [NUM_EX-1:0]       ready_in,
    output logic                    valid_out,
    output logic [DATAW-1:0]        data_out,
    input  logic                    ready_out,
    output logic [IDX_W-1:0]        grant_idx,
    output logic [PERF_W-1:0]       commit_count
);

    logic              valid_out_r;
    logic [DATAW-1:0]  data_out_r;
    logic [IDX_W-1:0]  grant_idx_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic              lock_r;
    logic [IDX_W-1:0]  lock_idx_r;
    logic [PERF_W-1:0] commit_count_r;

    logic              grant_valid_s;
    logic [IDX_W-1:0]  grant_s;
    logic              load_en_s;
    logic              accept_s;
    logic [DATAW-1:0]  sel_data_s;
    logic              sel_sop_s;
    logic              sel_eop_s;

    // The output slot can take new data when empty or when it is being drained.
    always_comb begin
        load_en_s  = !valid_out_r | ready_out;
        accept_s   = load_en_s & grant_valid_s;
        sel_data_s = data_in[int'(grant_s)*DATAW +: DATAW];
        sel_sop_s  = sel_data_s[1];
        sel_eop_s  = sel_data_s[0];
    end

    // Grant selection: the locked owner alone while an instruction is open,
    // otherwise the first valid input after the last grant (scanned from the
    // far end so the nearest candidate is written last and wins).
    always_comb begin : grant_sel
        logic [IDX_W-1:0] cand;
        cand          = {IDX_W{1'b0}};
        grant_valid_s = 1'b0;
        grant_s       = {IDX_W{1'b0}};
        if (lock_r) begin
            grant_valid_s = valid_in[lock_idx_r];
            grant_s       = lock_idx_r;
        end else begin
            for (int k = NUM_EX; k >= 1; k--) begin
                cand          = IDX_W'((int'(rr_ptr_r) + k) % NUM_EX);
                grant_valid_s = grant_valid_s | valid_in[cand];
                grant_s       = valid_in[cand] ? cand : grant_s;
            end
        end
    end

    // One-hot ready toward the granted source; silenced while reset is held.
    always_comb begin
        ready_in = {NUM_EX{1'b0}};
        for (int i = 0; i < NUM_EX; i++) begin
            ready_in[i] = !reset & accept_s & (grant_s == IDX_W'(i));
        end
    end

    // Output register: reloads from the granted input, holds under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out_r <= 1'b0;
            data_out_r  <= {DATAW{1'b0}};
            grant_idx_r <= {IDX_W{1'b0}};
        end else if (load_en_s) begin
            valid_out_r <= grant_valid_s;
            if (grant_valid_s) begin
                data_out_r  <= sel_data_s;
                grant_idx_r <= grant_s;
            end
        end
    end

    // Arbiter state: round-robin pointer and the open-instruction lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r   <= IDX_W'(NUM_EX - 1);
            lock_r     <= 1'b0;
            lock_idx_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            rr_ptr_r <= grant_s;
            if (sel_eop_s) begin
                lock_r <= 1'b0;
            end else if (sel_sop_s) begin
                lock_r     <= 1'b1;
                lock_idx_r <= grant_s;
            end
        end
    end

    // Committed-instruction counter: one per eop packet leaving the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_count_r <= {PERF_W{1'b0}};
        end else if (valid_out_r && ready_out && data_out_r[0]) begin
            commit_count_r <= commit_count_r + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign valid_out    = valid_out_r;
    assign data_out     = data_out_r;
    assign grant_idx    = grant_idx_r;
    assign commit_count = commit_count_r;

endmodule

// File: tb/tb_vx_commit_arb.sv
// Bench for vx_commit_arb: a 4-input/44-bit-counter instance and a
// 1-input/4-bit-counter instance, each checked every cycle against a
// transaction-level model, plus literal expectations per scenario.
module tb_vx_commit_arb;

    logic         clk;
    logic         reset;
    logic [3:0]   vin4;
    logic [255:0] din4;
    logic [3:0]   rdy4;
    logic         vout4;
    logic [63:0]  dout4;
    logic         rout4;
    logic [1:0]   gidx4;
    logic [43:0]  cnt4;

    logic         vin1;
    logic [63:0]  din1;
    logic         rdy1;
    logic         vout1;
    logic [63:0]  dout1;
    logic         rout1;
    logic [0:0]   gidx1;
    logic [3:0]   cnt1;

    int n_cmp = 0;
    int n_fail = 0;

    vx_commit_arb #(.NUM_EX(4), .DATAW(64), .PERF_W(44)) u4 (
        .clk(clk), .reset(reset), .valid_in(vin4), .data_in(din4), .ready_in(rdy4),
        .valid_out(vout4), .data_out(dout4), .ready_out(rout4),
        .grant_idx(gidx4), .commit_count(cnt4));

    vx_commit_arb #(.NUM_EX(1), .DATAW(64), .PERF_W(4)) u1 (
        .clk(clk), .reset(reset), .valid_in(vin1), .data_in(din1), .ready_in(rdy1),
        .valid_out(vout1), .data_out(dout1), .ready_out(rout1),
        .grant_idx(gidx1), .commit_count(cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [63:0] d;
        int          i;
        int          last;
        bit          lk;
        int          own;
        longint      cnt;
    } model_t;

    model_t m4, m1;

    function automatic model_t model_reset(int n);
        model_t s;
        s.v = 1'b0; s.d = 64'd0; s.i = 0; s.last = n - 1;
        s.lk = 1'b0; s.own = 0; s.cnt = 0;
        return s;
    endfunction

    // Who may send: the open instruction's owner, else first valid after last grant.
    function automatic void pick(int n, logic [3:0] v, model_t s, output bit f, output int g);
        f = 1'b0;
        g = 0;
        if (s.lk) begin
            f = v[s.own];
            g = s.own;
        end else begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (s.last + k) % n;
                if (!f && v[c]) begin
                    f = 1'b1;
                    g = c;
                end
            end
        end
    endfunction

    function automatic model_t step(model_t s, int n, logic [3:0] v, logic [255:0] d, logic rout);
        model_t t;
        bit f;
        int g;
        t = s;
        if (s.v && rout && s.d[0]) t.cnt = s.cnt + 1;
        pick(n, v, s, f, g);
        if (!s.v || rout) begin
            t.v = f;
            if (f) begin
                t.d = d[g*64 +: 64];
                t.i = g;
                t.last = g;
                if (t.d[0]) t.lk = 1'b0;
                else if (t.d[1]) begin
                    t.lk = 1'b1;
                    t.own = g;
                end
            end
        end
        return t;
    endfunction

    function automatic logic [63:0] exp_ready(model_t s, int n, logic [3:0] v, logic rout);
        bit f;
        int g;
        pick(n, v, s, f, g);
        return (f && (!s.v || rout)) ? (64'd1 << g) : 64'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m4 <= model_reset(4);
            m1 <= model_reset(1);
        end else begin
            m4 <= step(m4, 4, vin4, din4, rout4);
            m1 <= step(m1, 1, {3'b000, vin1}, {192'd0, din1}, rout1);
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("u4_valid_out", 64'(vout4), 64'(m4.v));
            chk("u4_grant_idx", 64'(gidx4), 64'(m4.i));
            chk("u4_data_out", dout4, m4.d);
            chk("u4_commit_count", 64'(cnt4), 64'(m4.cnt[43:0]));
            chk("u4_ready_in", 64'(rdy4), exp_ready(m4, 4, vin4, rout4));
            chk("u1_valid_out", 64'(vout1), 64'(m1.v));
            chk("u1_grant_idx", 64'(gidx1), 64'(m1.i));
            chk("u1_data_out", dout1, m1.d);
            chk("u1_commit_count", 64'(cnt1), 64'(m1.cnt[3:0]));
            chk("u1_ready_in", 64'(rdy1), exp_ready(m1, 1, {3'b000, vin1}, rout1));
        end
    end

    // ---------------- sources and output logs ----------------
    logic [63:0] src [4][32];
    int          wr [4];
    int          rd [4];
    logic [63:0] src1 [32];
    int          wr1, rd1;
    logic [3:0]  acc4;
    logic        acc1;
    int          ord4 [$];
    logic [63:0] out1 [$];

    function automatic logic [63:0] pkt(int s, int seq, bit sop, bit eop);
        return {40'hC0FFEE0000, 8'(s), 8'(seq), 6'd0, sop, eop};
    endfunction

    function automatic logic [63:0] packord();
        logic [63:0] r;
        r = 64'd0;
        foreach (ord4[j]) r = (r << 4) | 64'(ord4[j]);
        return r;
    endfunction

    function automatic bit idle();
        bit r;
        r = !vout4 && !vout1 && (rd1 == wr1);
        for (int i = 0; i < 4; i++) if (rd[i] != wr[i]) r = 1'b0;
        return r;
    endfunction

    task automatic push(int i, bit sop, bit eop);
        src[i][wr[i]] = pkt(i, wr[i], sop, eop);
        wr[i]++;
    endtask

    task automatic push1(bit sop, bit eop);
        src1[wr1] = pkt(9, wr1, sop, eop);
        wr1++;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            vin4[i] = (rd[i] < wr[i]);
            din4[i*64 +: 64] = (rd[i] < wr[i]) ? src[i][rd[i]] : 64'd0;
        end
        vin1 = (rd1 < wr1);
        din1 = (rd1 < wr1) ? src1[rd1] : 64'd0;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        acc4 = vin4 & rdy4;
        acc1 = vin1 & rdy1;
        if (vout4 && rout4) ord4.push_back(int'(gidx4));
        if (vout1 && rout1) out1.push_back(dout1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc4[i]) rd[i]++;
        if (acc1) rd1++;
        drive();
    endtask

    task automatic run_idle(string nm, int budget);
        int c;
        c = 0;
        while (!idle() && c < budget) begin
            tick();
            c++;
        end
        if (!idle()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        rd1 = 0;
        wr1 = 0;
        drive();
        ord4.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hd;
        logic [63:0] hg;
        int          b2;
        int          viol;

        reset = 1'b1;
        rout4 = 1'b0;
        rout1 = 1'b0;
        vin4  = 4'hF;
        din4  = {4{64'h3}};
        vin1  = 1'b1;
        din1  = 64'h3;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        rd1 = 0;
        wr1 = 0;
        #3;
        chk("rst_valid_out", 64'(vout4), 64'd0);
        chk("rst_grant_idx", 64'(gidx4), 64'd0);
        chk("rst_commit_count", 64'(cnt4), 64'd0);
        chk("rst_ready_in", 64'(rdy4), 64'd0);
        chk("rst_ready_in_u1", 64'(rdy1), 64'd0);
        do_reset();

        // Single packets on all inputs: grants 0,1,2,3,0.
        rout4 = 1'b1;
        push(0, 1'b1, 1'b1); push(1, 1'b1, 1'b1); push(2, 1'b1, 1'b1);
        push(3, 1'b1, 1'b1); push(0, 1'b1, 1'b1);
        drive();
        run_idle("t1", 40);
        chk("t1_n_out", 64'(ord4.size()), 64'd5);
        chk("t1_order", packord(), 64'h01230);
        chk("t1_commit_count", 64'(cnt4), 64'd5);

        // Atomicity: input 2 three-packet instruction vs singles on 0 and 3.
        ord4.delete();
        b2 = wr[2];
        push(2, 1'b1, 1'b0); push(2, 1'b0, 1'b0); push(2, 1'b0, 1'b1);
        push(3, 1'b1, 1'b1); push(0, 1'b1, 1'b1);
        drive();
        viol = 0;
        for (int c = 0; c < 40 && !idle(); c++) begin
            tick();
            if (rd[2] > b2 && rd[2] < b2 + 3 && (rdy4[0] || rdy4[3])) viol++;
        end
        chk("t2_lock_ready", 64'(viol), 64'd0);
        chk("t2_n_out", 64'(ord4.size()), 64'd5);
        chk("t2_order", packord(), 64'h22230);
        chk("t2_commit_count", 64'(cnt4), 64'd8);

        // Backpressure: output held for 5 cycles, then drains without loss.
        ord4.delete();
        rout4 = 1'b0;
        push(1, 1'b1, 1'b1); push(1, 1'b1, 1'b1);
        push(2, 1'b1, 1'b1); push(2, 1'b1, 1'b1);
        drive();
        tick();
        hd = dout4;
        hg = 64'(gidx4);
        chk("t3_first_idx", hg, 64'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_valid", 64'(vout4), 64'd1);
            chk("t3_hold_data", dout4, hd);
            chk("t3_hold_idx", 64'(gidx4), hg);
            chk("t3_hold_ready", 64'(rdy4), 64'd0);
        end
        rout4 = 1'b1;
        run_idle("t3", 40);
        chk("t3_n_out", 64'(ord4.size()), 64'd4);
        chk("t3_order", packord(), 64'h1212);
        chk("t3_commit_count", 64'(cnt4), 64'd12);

        // Counter: 10 output packets, 4 of them eop.
        do_reset();
        rout4 = 1'b1;
        push(0, 1'b1, 1'b0); push(0, 1'b0, 1'b0); push(0, 1'b0, 1'b1);
        push(0, 1'b1, 1'b1);
        push(0, 1'b1, 1'b0); push(0, 1'b0, 1'b0); push(0, 1'b0, 1'b0);
        push(0, 1'b0, 1'b0); push(0, 1'b0, 1'b1);
        push(0, 1'b1, 1'b1);
        drive();
        run_idle("t4", 60);
        chk("t4_n_out", 64'(ord4.size()), 64'd10);
        chk("t4_commit_count", 64'(cnt4), 64'd4);

        // Reset in the middle of a locked instruction from input 1.
        rout4 = 1'b0;
        push(1, 1'b1, 1'b0);
        drive();
        tick();
        chk("t5_pre_valid", 64'(vout4), 64'd1);
        chk("t5_pre_idx", 64'(gidx4), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(vout4), 64'd0);
        chk("t5_rst_idx", 64'(gidx4), 64'd0);
        chk("t5_rst_count", 64'(cnt4), 64'd0);
        chk("t5_rst_ready", 64'(rdy4), 64'd0);
        do_reset();
        rout4 = 1'b1;
        push(2, 1'b1, 1'b1); push(0, 1'b1, 1'b1);
        drive();
        run_idle("t5", 20);
        chk("t5_n_out", 64'(ord4.size()), 64'd2);
        chk("t5_order", packord(), 64'h02);

        // Single-input instance: pipeline register with random backpressure.
        push1(1'b1, 1'b0); push1(1'b0, 1'b0); push1(1'b0, 1'b1); push1(1'b1, 1'b1);
        push1(1'b1, 1'b0); push1(1'b0, 1'b1); push1(1'b1, 1'b1); push1(1'b1, 1'b1);
        for (int j = 0; j < 12; j++) push1(1'b1, 1'b1);
        drive();
        for (int c = 0; c < 400 && !idle(); c++) begin
            rout1 = 1'($urandom_range(0, 1));
            tick();
        end
        rout1 = 1'b1;
        run_idle("t6", 20);
        chk("t6_n_out", 64'(out1.size()), 64'd20);
        for (int j = 0; j < 20 && j < out1.size(); j++) chk("t6_seq", out1[j], src1[j]);
        chk("t6_grant_idx", 64'(gidx1), 64'd0);
        chk("t6_commit_wrap", 64'(cnt1), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
